// File: rtl/seq_multiplier.sv
// Iterative radix-2 shift-add unsigned multiplier: 2n-bit product in n cycles via a ripple-carry adder.
// Optional zero-operand fast path enabled by defining MUL_ZERO_SKIP_EN.

module seq_rca #(
    parameter int n = 32
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         cin,
    output logic [n-1:0] sum,
    output logic         cout
);
    logic [n:0] carry;

    assign carry[0] = cin;

    generate
        for (genvar gi = 0; gi < n; gi++) begin : g_bit
            assign sum[gi]       = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = carry[n];
endmodule

module seq_multiplier #(
    parameter int n = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [n-1:0]   A,
    input  logic [n-1:0]   B,
    output logic           busy,
    output logic           done,
    output logic [2*n-1:0] Product
);
    localparam int CW = (n > 1) ? $clog2(n) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_reg;
    state_t         state_next;
    logic [n-1:0]   mcand_reg;
    logic [n-1:0]   acc_hi_reg;
    logic [n-1:0]   acc_lo_reg;
    logic [CW-1:0]  count_reg;
    logic [2*n-1:0] product_reg;

    logic           accept;
    logic           last_iter;
    logic           zero_op;
    logic [n-1:0]   addend;
    logic [n-1:0]   sum;
    logic           cout;
    logic [2*n-1:0] shifted;

    assign accept    = start && ((state_reg == IDLE) || (state_reg == DONE));
    assign last_iter = (count_reg == CW'(n - 1));

`ifdef MUL_ZERO_SKIP_EN
    assign zero_op = (A == '0) || (B == '0);
`else
    assign zero_op = 1'b0;
`endif

    // Only add the multiplicand when the current multiplier bit is set.
    assign addend = acc_lo_reg[0] ? mcand_reg : '0;

    seq_rca #(
        .n(n)
    ) u_rca (
        .a   (acc_hi_reg),
        .b   (addend),
        .cin (1'b0),
        .sum (sum),
        .cout(cout)
    );

    // The (2n+1)-bit {cout, sum, acc_lo} shifted right by one keeps exactly 2n bits.
    assign shifted = {cout, sum, acc_lo_reg[n-1:1]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = zero_op ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_next = zero_op ? DONE : BUSY;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand_reg   <= '0;
            acc_hi_reg  <= '0;
            acc_lo_reg  <= '0;
            count_reg   <= '0;
            product_reg <= '0;
        end else if (accept) begin
            mcand_reg  <= A;
            acc_hi_reg <= '0;
            acc_lo_reg <= B;
            count_reg  <= '0;
            if (zero_op) begin
                product_reg <= '0;
            end
        end else if (state_reg == BUSY) begin
            {acc_hi_reg, acc_lo_reg} <= shifted;
            count_reg                <= count_reg + CW'(1);
            if (last_iter) begin
                product_reg <= shifted;
            end
        end
    end

    assign busy    = (state_reg == BUSY);
    assign done    = (state_reg == DONE);
    assign Product = product_reg;
endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: cycle-level reference model plus hand-computed result checks.
module tb_seq_multiplier;
    localparam int N = 32;

    logic           clk   = 1'b0;
    logic           rst   = 1'b0;
    logic           start = 1'b0;
    logic [N-1:0]   A     = '0;
    logic [N-1:0]   B     = '0;
    logic           busy;
    logic           done;
    logic [2*N-1:0] Product;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: an accepted job occupies N cycles, then presents A*B for one cycle.
    int             m_left = 0;
    logic           m_done = 1'b0;
    logic [2*N-1:0] m_prod = '0;
    logic [2*N-1:0] m_pend = '0;

    always #5 clk = ~clk;

    seq_multiplier #(
        .n(N)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .done   (done),
        .Product(Product)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_prod <= '0;
            m_pend <= '0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            m_done <= (m_left == 1);
            if (m_left == 1) begin
                m_prod <= m_pend;
            end
        end else if (start) begin
`ifdef MUL_ZERO_SKIP_EN
            if (A == 0 || B == 0) begin
                m_left <= 0;
                m_done <= 1'b1;
                m_prod <= '0;
            end else begin
                m_left <= N;
                m_done <= 1'b0;
                m_pend <= 64'(A) * 64'(B);
            end
`else
            m_left <= N;
            m_done <= 1'b0;
            m_pend <= 64'(A) * 64'(B);
`endif
        end else begin
            m_done <= 1'b0;
        end
    end

    always @(negedge clk) begin
        check("busy", 64'(busy), 64'(m_left > 0));
        check("done", 64'(done), 64'(m_done));
        check("product", Product, m_prod);
        check("busy_and_done", 64'(busy & done), 64'(0));
    end

    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b);
        @(negedge clk);
        start = 1'b1;
        A     = a;
        B     = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!done && cnt < 200);
        if (!done) begin
            check("done_timeout", 64'(0), 64'(1));
        end
    endtask

    initial begin
        int c;
        #1;
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_product", Product, 64'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Basic product and latency
        issue(32'd3, 32'd5);
        wait_done(c);
        check("lat_3x5", 64'(c), 64'(N));
        check("prod_3x5", Product, 64'h0000_0000_0000_000F);

        // Maximum operands
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(c);
        check("lat_max", 64'(c), 64'(N));
        check("prod_max", Product, 64'hFFFF_FFFE_0000_0001);

        // start held through BUSY, then back-to-back re-accept from DONE
        @(negedge clk);
        start = 1'b1;
        A     = 32'd7;
        B     = 32'd9;
        @(negedge clk);
        A = 32'hFFFF_FFFF;
        B = 32'hFFFF_FFFF;
        wait_done(c);
        check("lat_held_first", 64'(c), 64'(N));
        check("prod_held_first", Product, 64'd63);
        wait_done(c);
        check("lat_held_second", 64'(c), 64'(N + 1));
        check("prod_held_second", Product, 64'hFFFF_FFFE_0000_0001);
        start = 1'b0;

        // Product holds through the next BUSY
        issue(32'd6, 32'd7);
        wait_done(c);
        check("prod_6x7", Product, 64'd42);
        issue(32'd10, 32'd10);
        for (int i = 0; i < N - 1; i++) begin
            @(negedge clk);
            check("prod_hold", Product, 64'd42);
        end
        @(negedge clk);
        check("done_10x10", 64'(done), 64'(1));
        check("prod_10x10", Product, 64'd100);

        // Asynchronous reset mid-operation
        issue(32'h1234, 32'h5678);
        repeat (10) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        check("abort_product", Product, 64'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        issue(32'd2, 32'd2);
        wait_done(c);
        check("lat_2x2", 64'(c), 64'(N));
        check("prod_2x2", Product, 64'd4);

        // Zero operand
        issue(32'd0, 32'hABCD);
`ifdef MUL_ZERO_SKIP_EN
        check("zero_done", 64'(done), 64'(1));
        check("zero_busy", 64'(busy), 64'(0));
        check("zero_product", Product, 64'h0);
`else
        wait_done(c);
        check("lat_zero", 64'(c), 64'(N));
        check("zero_product", Product, 64'h0);
`endif
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end
endmodule
